// File: rtl/srff_pkg.sv
// rtl/srff_pkg.sv - SR flip-flop encodings and excitation helper shared by the SR-flop counters
package srff_pkg;

  // Bit order is {S,R}
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_CLR  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

  function automatic logic [1:0] sr_excite(input logic present, input logic next);
    return {~present & next, present & ~next};
  endfunction

endpackage

// File: rtl/srff_cell.sv
// rtl/srff_cell.sv - 1-bit clocked SR flip-flop; SRFF_DOWN_ILLEGAL_CHK_EN enables the S&R report
module srff_cell
  import srff_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q,
  output logic ill
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({s, r})
        SR_SET:  q <= 1'b1;
        SR_CLR:  q <= 1'b0;
        default: q <= q;  // SR_HOLD and SR_ILL both keep the bit
      endcase
    end
  end

`ifdef SRFF_DOWN_ILLEGAL_CHK_EN
  assign ill = s & r;
`else
  assign ill = 1'b0;
`endif

endmodule

// File: rtl/sync_down_srff.sv
// rtl/sync_down_srff.sv - synchronous SR-flop down counter with load, zero, borrow and sr_err
// SRFF_DOWN_ILLEGAL_CHK_EN enables the sticky illegal-excitation monitor.
module sync_down_srff
  import srff_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow,
  output logic             sr_err
);

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] s_vec;
  logic [WIDTH-1:0] r_vec;
  logic [WIDTH-1:0] ill_vec;

  // Load is applied through the same S/R cells by exciting toward din.
  always_comb begin
    target = q;
    if (load) begin
      target = din;
    end else if (en) begin
      target = q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    s_vec = '0;
    r_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {s_vec[i], r_vec[i]} = sr_excite(q[i], target[i]);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    srff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .s     (s_vec[g]),
      .r     (r_vec[g]),
      .q     (q[g]),
      .ill   (ill_vec[g])
    );
  end

  assign zero = (q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      borrow <= 1'b0;
    end else begin
      borrow <= en & ~load & zero;
    end
  end

`ifdef SRFF_DOWN_ILLEGAL_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_err <= 1'b0;
    end else if (|ill_vec) begin
      sr_err <= 1'b1;
    end
  end
`else
  // Cells report constant 0 here, so this is a tie-off.
  assign sr_err = |ill_vec;
`endif

endmodule

// File: tb/tb_sync_down_srff.sv
// tb/tb_sync_down_srff.sv - scoreboard bench for sync_down_srff
module tb_sync_down_srff;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = 4'h0;
  logic [3:0] q;
  logic       zero;
  logic       borrow;
  logic       sr_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] q;
    logic       borrow;
    logic       zero;
    logic       sr_err;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_q = 4'h0;
  logic       m_b = 1'b0;
  logic       m_e = 1'b0;

  sync_down_srff #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .load   (load),
    .din    (din),
    .q      (q),
    .zero   (zero),
    .borrow (borrow),
    .sr_err (sr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic e, input logic [3:0] d,
                      input logic frc, input string tag);
    exp_t x;
    @(negedge clk);
    reset = r;
    load  = l;
    en    = e;
    din   = d;
    if (frc) begin
      force dut.s_vec = 4'b0100;
      force dut.r_vec = 4'b0100;
    end
    if (r) begin
      m_q = 4'h0; m_b = 1'b0; m_e = 1'b0;
    end else if (l) begin
      m_q = d; m_b = 1'b0;
    end else if (e) begin
      m_b = (m_q == 4'h0);
      m_q = m_q - 4'h1;
    end else begin
      m_b = 1'b0;
    end
`ifdef SRFF_DOWN_ILLEGAL_CHK_EN
    if (frc && !r) m_e = 1'b1;
`endif
    x.q = m_q; x.borrow = m_b; x.zero = (m_q == 4'h0); x.sr_err = m_e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (frc) begin
      release dut.s_vec;
      release dut.r_vec;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check({tag, "_q"},      {28'd0, q},      {28'd0, x.q});
      check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, x.borrow});
      check({tag, "_zero"},   {31'd0, zero},   {31'd0, x.zero});
      check({tag, "_sr_err"}, {31'd0, sr_err}, {31'd0, x.sr_err});
    end
  endtask

  initial begin
    step(1, 0, 0, 4'h0, 0, "reset");
    step(1, 0, 1, 4'h5, 0, "reset_en");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 4'h0, 0, "count_from_0");

    step(0, 1, 0, 4'h7, 0, "load7");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'hA, 0, "hold");

    step(0, 1, 1, 4'h1, 0, "load1_en");
    step(0, 0, 1, 4'h0, 0, "to_zero");
    step(0, 0, 1, 4'h0, 0, "wrap");
    step(0, 0, 0, 4'h0, 0, "after_wrap");

    step(0, 1, 0, 4'h3, 0, "load3");
    step(0, 1, 1, 4'h9, 0, "load_beats_en");
    step(0, 0, 1, 4'h0, 0, "dec_from_9");

    step(0, 1, 0, 4'h6, 0, "load6");
    step(1, 0, 1, 4'h0, 0, "reset_mid");
    step(0, 0, 1, 4'h0, 0, "resume");
    step(0, 0, 1, 4'h0, 0, "resume2");

    step(0, 1, 0, 4'h4, 0, "load4");
    step(0, 0, 0, 4'h0, 1, "force_ill");
    step(0, 0, 1, 4'h0, 0, "sticky1");
    step(0, 0, 1, 4'h0, 0, "sticky2");
    step(0, 1, 0, 4'h0, 0, "sticky_load");
    step(1, 0, 0, 4'h0, 0, "clear_err");
    step(0, 0, 1, 4'h0, 0, "post_clear");

    check("sb_drained", {31'd0, sb.size() == 0}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
